// File: rtl/vec_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vec_loader_pkg
//  Purpose  : Shared sizing for the vector loader and the dot-product stages.
//             Holds element/vector defaults, the slot-index width, the
//             handoff-counter width and the single flattened-vector packing
//             rule (element i lives in bits [i*N +: N]).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package vec_loader_pkg;

  localparam int N_DEF     = 8;                 // element width in bits
  localparam int LEN_DEF   = 4;                 // elements per vector (>= 2)
  localparam int IDX_W_DEF = $clog2(LEN_DEF);   // slot index width
  localparam int VCNT_W    = 16;                // handoff counter width

  // Width of one flattened vector. Every block that packs or unpacks a
  // vector uses this so the packing rule lives in one place.
  function automatic int flat_width(input int n, input int len);
    return n * len;
  endfunction

  localparam int VEC_W_DEF = flat_width(N_DEF, LEN_DEF);

endpackage
`default_nettype wire

// File: rtl/vec_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : vec_loader_if
//  Purpose  : Element-input stream and vector-output stream of vec_loader.
//  Ports    : in_valid/in_ready/in_a/in_b/in_last  element pair stream
//             out_valid/out_ready/out_a/out_b       flattened vector stream
//  Modports : slave  - the loader's view
//             master - the surrounding logic's view (feeder + consumer)
//  Revision : 1.0 - initial release
// ============================================================================
interface vec_loader_if
  import vec_loader_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int LEN = LEN_DEF
);

  logic                          in_valid;
  logic                          in_ready;
  logic [N-1:0]                  in_a;
  logic [N-1:0]                  in_b;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [flat_width(N,LEN)-1:0]  out_a;
  logic [flat_width(N,LEN)-1:0]  out_b;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_a, out_b
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_a, out_b
  );

endinterface
`default_nettype wire

// File: rtl/vec_bank.sv
`default_nettype none
// ============================================================================
//  Module   : vec_bank
//  Purpose  : One ping-pong bank: LEN x N a-data and b-data registers with an
//             indexed write port, plus a full flag.
//  Ports    : clk, rst_n             clock, async active-low reset
//             i_we, i_idx            write enable and slot index
//             i_a, i_b               element data written to slot i_idx
//             i_set_full             mark bank full (vector complete)
//             i_clear_full           mark bank empty (vector handed off)
//             o_full                 full flag
//             o_a, o_b               flattened bank contents
//  Revision : 1.0 - initial release
// ============================================================================
module vec_bank
  import vec_loader_pkg::*;
#(
  parameter  int N     = N_DEF,
  parameter  int LEN   = LEN_DEF,
  localparam int IDX_W = $clog2(LEN),
  localparam int VEC_W = flat_width(N, LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [N-1:0]     i_a,
  input  logic [N-1:0]     i_b,
  input  logic             i_set_full,
  input  logic             i_clear_full,
  output logic             o_full,
  output logic [VEC_W-1:0] o_a,
  output logic [VEC_W-1:0] o_b
);

  logic [VEC_W-1:0] r_a;
  logic [VEC_W-1:0] r_b;
  logic             r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_we) begin
        r_a[i_idx*N +: N] <= i_a;
        r_b[i_idx*N +: N] <= i_b;
      end
      // Set and clear never target the same bank in one cycle: filling
      // needs the bank empty, presenting needs it full.
      if (i_set_full) begin
        r_full <= 1'b1;
      end else if (i_clear_full) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_a    = r_a;
  assign o_b    = r_b;

endmodule
`default_nettype wire

// File: rtl/vec_loader.sv
`default_nettype none
// ============================================================================
//  Module   : vec_loader
//  Purpose  : Assembles element pairs into LEN-element vector pairs using two
//             ping-pong banks and presents each complete pair to the
//             dot-product unit over a valid/ready handshake.
//  Ports    : clk, rst_n      clock, async active-low reset
//             bus (slave)     element input stream and vector output stream
//             o_vec_count     vectors handed off, wraps at 2^16
//             o_err           sticky framing error (cleared only by reset)
//  Revision : 1.0 - initial release
// ============================================================================
module vec_loader
  import vec_loader_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int LEN = LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  vec_loader_if.slave       bus,
  output logic [VCNT_W-1:0] o_vec_count,
  output logic              o_err
);

  localparam int IDX_W = $clog2(LEN);
  localparam int VEC_W = flat_width(N, LEN);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(LEN - 1);

  logic              r_wbank;      // bank being filled
  logic              r_rbank;      // bank being presented
  logic [IDX_W-1:0]  r_idx;        // next slot in the fill bank
  logic              r_err;
  logic [VCNT_W-1:0] r_vec_count;

  logic              w_full   [2];
  logic [VEC_W-1:0]  w_bank_a [2];
  logic [VEC_W-1:0]  w_bank_b [2];
  logic              w_we     [2];
  logic              w_set    [2];
  logic              w_clr    [2];

  logic w_in_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_handoff;
  logic w_last_slot;

  // Both flags are straight muxes of registers, so out_ready never reaches
  // in_ready combinationally.
  assign w_in_ready  = !w_full[r_wbank];
  assign w_out_valid =  w_full[r_rbank];
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_handoff   = w_out_valid && bus.out_ready;
  assign w_last_slot = (r_idx == C_LAST_IDX);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic c_bank_id = 1'(gi);

      assign w_we[gi]  = w_accept && (r_wbank == c_bank_id);
      // A vector completes on the last slot whether or not in_last came
      // with it; a missing in_last only raises err.
      assign w_set[gi] = w_we[gi] && w_last_slot;
      assign w_clr[gi] = w_handoff && (r_rbank == c_bank_id);

      vec_bank #(
        .N   (N),
        .LEN (LEN)
      ) u_bank (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_we         (w_we[gi]),
        .i_idx        (r_idx),
        .i_a          (bus.in_a),
        .i_b          (bus.in_b),
        .i_set_full   (w_set[gi]),
        .i_clear_full (w_clr[gi]),
        .o_full       (w_full[gi]),
        .o_a          (w_bank_a[gi]),
        .o_b          (w_bank_b[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_vec_count <= '0;
    end else begin
      if (w_accept) begin
        if (w_last_slot) begin
          r_wbank <= ~r_wbank;
          r_idx   <= '0;
          if (!bus.in_last) begin
            r_err <= 1'b1;
          end
        end else if (bus.in_last) begin
          // Early in_last: drop the partial vector and restart at slot 0
          // of the same bank; its stale slots get overwritten.
          r_idx <= '0;
          r_err <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (w_handoff) begin
        r_rbank     <= ~r_rbank;
        r_vec_count <= r_vec_count + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_a     = r_rbank ? w_bank_a[1] : w_bank_a[0];
  assign bus.out_b     = r_rbank ? w_bank_b[1] : w_bank_b[0];
  assign o_vec_count   = r_vec_count;
  assign o_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vec_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_loader
//  Purpose  : Self-checking bench for vec_loader. A behavioural model turns
//             accepted elements into expected vectors pushed onto a queue;
//             a monitor pops and compares on every handoff and checks the
//             handshake flags, counter and error flag every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vec_loader;
  import vec_loader_pkg::*;

  localparam int N     = 8;
  localparam int LEN   = 4;
  localparam int VEC_W = N * LEN;

  typedef struct {
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic [VCNT_W-1:0] vec_count;
  logic              err;

  vec_loader_if #(.N(N), .LEN(LEN)) bus ();

  vec_loader #(.N(N), .LEN(LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_vec_count (vec_count),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  vec_t             exp_q[$];      // complete vectors not yet handed off
  logic [N-1:0]     m_a [LEN];
  logic [N-1:0]     m_b [LEN];
  int               m_cnt = 0;     // elements gathered for current vector
  logic [VCNT_W-1:0] m_vc = '0;
  logic             m_err = 1'b0;

  function automatic void model_accept(input logic [N-1:0] a, input logic [N-1:0] b, input logic last);
    vec_t v;
    m_a[m_cnt] = a;
    m_b[m_cnt] = b;
    if (m_cnt == LEN - 1) begin
      for (int k = 0; k < LEN; k++) begin
        v.a[k*N +: N] = m_a[k];
        v.b[k*N +: N] = m_b[k];
      end
      exp_q.push_back(v);
      if (!last) m_err = 1'b1;
      m_cnt = 0;
    end else if (last) begin
      m_cnt = 0;
      m_err = 1'b1;
    end else begin
      m_cnt++;
    end
  endfunction

  // Monitor: compare the DUT against the model's current state, then advance
  // the model with the events the next rising edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0;
      m_vc  = '0;
      m_err = 1'b0;
    end else begin
      bit exp_valid, exp_ready, do_hand, do_acc;
      exp_valid = (exp_q.size() > 0);
      exp_ready = (exp_q.size() < 2);
      check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
      check("in_ready",  64'(bus.in_ready),  64'(exp_ready));
      check("vec_count", 64'(vec_count),     64'(m_vc));
      check("err",       64'(err),           64'(m_err));
      if (exp_valid) begin
        check("out_a", 64'(bus.out_a), 64'(exp_q[0].a));
        check("out_b", 64'(bus.out_b), 64'(exp_q[0].b));
      end
      do_hand = exp_valid && bus.out_ready;
      do_acc  = exp_ready && bus.in_valid;
      if (do_hand) begin
        void'(exp_q.pop_front());
        m_vc = m_vc + 1'b1;
      end
      if (do_acc) model_accept(bus.in_a, bus.in_b, bus.in_last);
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic last);
    int waits = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready) begin
      waits++;
      if (waits > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", waits);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_vec(input bit rnd);
    for (int j = 0; j < LEN; j++) begin
      if (rnd) send(N'($urandom), N'($urandom), j == LEN - 1);
      else     send(N'(j + 1), N'(2 * (j + 1)), j == LEN - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  bit rnd_done;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_a",     64'(bus.out_a),     64'd0);
    check("rst_vec_count", 64'(vec_count),     64'd0);

    // Single vector (1,2),(2,4),(3,6),(4,8)
    bus.out_ready = 1'b1;
    send_vec(1'b0);
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_out_a", 64'(bus.out_a),     64'h04030201);
    check("single_out_b", 64'(bus.out_b),     64'h08060402);
    idle(3);
    check("single_vec_count", 64'(vec_count), 64'd1);
    check("single_err",       64'(err),       64'd0);

    // Backpressure: three vectors with the consumer stalled
    bus.out_ready = 1'b0;
    fork
      begin
        for (int v = 0; v < 3; v++) send_vec(1'b1);
      end
    join_none
    idle(14);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    wait fork;
    idle(4);
    check("bp_vec_count", 64'(vec_count), 64'd4);

    // Zero-bubble streaming of 10 vectors
    for (int v = 0; v < 10; v++) send_vec(1'b1);
    idle(3);
    check("stream_vec_count", 64'(vec_count), 64'd14);
    check("stream_err",       64'(err),       64'd0);

    // Early in_last on element index 1, then a good vector
    send(8'hAA, 8'hBB, 1'b0);
    send(8'hCC, 8'hDD, 1'b1);
    idle(2);
    check("early_err",   64'(err),           64'd1);
    check("early_noval", 64'(bus.out_valid), 64'd0);
    send_vec(1'b1);
    idle(3);
    check("early_vec_count", 64'(vec_count), 64'd15);

    // Missing in_last on element 3
    for (int j = 0; j < LEN; j++) send(N'($urandom), N'($urandom), 1'b0);
    idle(3);
    check("nolast_vec_count", 64'(vec_count), 64'd16);
    check("nolast_err",       64'(err),       64'd1);

    // Async reset mid-clock: one full bank pending plus two elements
    bus.out_ready = 1'b0;
    send_vec(1'b1);
    send(8'h11, 8'h22, 1'b0);
    send(8'h33, 8'h44, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready",  64'(bus.in_ready),  64'd1);
    check("arst_vec_count", 64'(vec_count),     64'd0);
    check("arst_err",       64'(err),           64'd0);
    check("arst_out_a",     64'(bus.out_a),     64'd0);
    idle(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_vec(1'b1);
    idle(3);
    check("arst_after_count", 64'(vec_count), 64'd1);

    // Randomised traffic: random consumer stalls, occasional framing faults
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          logic lst;
          lst = ((i % LEN) == LEN - 1);
          if ($urandom_range(0, 15) == 0) lst = ~lst;
          send(N'($urandom), N'($urandom), lst);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
